// File: rtl/irq_controller.sv
// Prioritised interrupt controller: latches rising-edge events, masks them, and serves one irq at a time with ack and hold-off.
// Define IRQ_SYNC_EN to pass event_in through a two-flop synchroniser (sources asynchronous to clk).
module irq_controller #(
  parameter int NUM_SRC    = 8,
  parameter int DATA_WIDTH = 64,
  parameter int HOLDOFF    = 4,
  localparam int IDW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] ctrl_word,
  input  logic [DATA_WIDTH-1:0] irq_enable,
  input  logic [NUM_SRC-1:0]    event_in,
  input  logic                  ack,
  output logic                  irq,
  output logic [IDW-1:0]        irq_id,
  output logic [NUM_SRC-1:0]    pending,
  output logic [DATA_WIDTH-1:0] status
);

  localparam int CNTW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t              state;
  logic [CNTW-1:0]     cnt;
  logic [NUM_SRC-1:0]  ev;
  logic [NUM_SRC-1:0]  prev;
  logic [NUM_SRC-1:0]  set;
  logic [NUM_SRC-1:0]  en;
  logic [NUM_SRC-1:0]  active;
  logic [NUM_SRC-1:0]  clr_mask;
  logic                gen;
  logic                unused_bits;

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync1;
  logic [NUM_SRC-1:0] sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= event_in;
      sync2 <= sync1;
    end
  end

  assign ev = sync2;
`else
  assign ev = event_in;
`endif

  assign gen         = ctrl_word[0];
  assign en          = irq_enable[NUM_SRC-1:0];
  assign set         = ev & ~prev;
  assign active      = pending & en;
  assign clr_mask    = NUM_SRC'(1) << irq_id;
  assign status      = DATA_WIDTH'(pending);
  assign unused_bits = ^{ctrl_word, irq_enable};

  function automatic logic [IDW-1:0] lowest(input logic [NUM_SRC-1:0] v);
    lowest = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest = IDW'(i);
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      irq     <= 1'b0;
      irq_id  <= '0;
      cnt     <= '0;
      pending <= '0;
      prev    <= '0;
    end else begin
      // Edge detectors keep tracking even while globally disabled.
      prev <= ev;
      if (!gen) begin
        state   <= IDLE;
        irq     <= 1'b0;
        cnt     <= '0;
        pending <= '0;
      end else begin
        pending <= pending | set;
        case (state)
          IDLE: begin
            if (|active) begin
              state  <= ASSERT;
              irq    <= 1'b1;
              irq_id <= lowest(active);
            end
          end
          ASSERT: begin
            if (ack) begin
              // A new edge on the acked source in the same cycle survives the clear.
              pending <= (pending & ~clr_mask) | set;
              irq     <= 1'b0;
              if (HOLDOFF == 0) begin
                state <= IDLE;
              end else begin
                state <= HOLD;
                cnt   <= CNTW'(HOLDOFF);
              end
            end else if (!en[irq_id]) begin
              state <= IDLE;
              irq   <= 1'b0;
            end
          end
          HOLD: begin
            if (cnt <= CNTW'(1)) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt - CNTW'(1);
            end
          end
          default: begin
            state <= IDLE;
            irq   <= 1'b0;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
